// File: rtl/simd_div_arbiter_if.sv
// Handshake bundle shared by the requesters, the divider arbiter and the divider.
// The arbiter takes the slave view; requesters plus divider form the master side.
interface simd_div_arbiter_if #(
    parameter int unsigned NrReq = 2
);
    logic [NrReq-1:0]       req_valid_i;
    logic [NrReq-1:0]       req_ready_o;
    logic [NrReq-1:0][63:0] req_operand_a_i;
    logic [NrReq-1:0][63:0] req_operand_b_i;
    logic [NrReq-1:0][6:0]  req_op_i;
    logic [NrReq-1:0][1:0]  req_vew_i;
    logic [NrReq-1:0][7:0]  req_be_i;
    logic [NrReq-1:0][7:0]  req_mask_i;

    logic        div_valid_o;
    logic        div_ready_i;
    logic [63:0] div_operand_a_o;
    logic [63:0] div_operand_b_o;
    logic [6:0]  div_op_o;
    logic [1:0]  div_vew_o;
    logic [7:0]  div_be_o;
    logic [7:0]  div_mask_o;

    logic        div_valid_i;
    logic        div_ready_o;
    logic [63:0] div_result_i;
    logic [7:0]  div_mask_i;

    logic [NrReq-1:0] rsp_valid_o;
    logic [NrReq-1:0] rsp_ready_i;
    logic [63:0]      rsp_result_o;
    logic [7:0]       rsp_mask_o;

    logic busy_o;

    modport slave (
        input  req_valid_i, req_operand_a_i, req_operand_b_i, req_op_i, req_vew_i,
               req_be_i, req_mask_i, div_ready_i, div_valid_i, div_result_i, div_mask_i,
               rsp_ready_i,
        output req_ready_o, div_valid_o, div_operand_a_o, div_operand_b_o, div_op_o,
               div_vew_o, div_be_o, div_mask_o, div_ready_o, rsp_valid_o, rsp_result_o,
               rsp_mask_o, busy_o
    );

    modport master (
        output req_valid_i, req_operand_a_i, req_operand_b_i, req_op_i, req_vew_i,
               req_be_i, req_mask_i, div_ready_i, div_valid_i, div_result_i, div_mask_i,
               rsp_ready_i,
        input  req_ready_o, div_valid_o, div_operand_a_o, div_operand_b_o, div_op_o,
               div_vew_o, div_be_o, div_mask_o, div_ready_o, rsp_valid_o, rsp_result_o,
               rsp_mask_o, busy_o
    );
endinterface

// File: rtl/simd_div_arbiter.sv
// Round-robin arbiter sharing one divider among NrReq requesters; an owner FIFO
// remembers issue order so results are steered back to the right requester.
//
// state    | meaning
// ARB_IDLE | winner picked combinationally each cycle from asserted req_valid_i
// ARB_LOCK | divider stalled the issue; grant index frozen until handshake
module simd_div_arbiter #(
    parameter int unsigned NrReq      = 2,
    parameter int unsigned OwnerDepth = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    simd_div_arbiter_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NrReq);
    localparam int unsigned PtrW = (OwnerDepth > 1) ? $clog2(OwnerDepth) : 1;
    localparam int unsigned CntW = $clog2(OwnerDepth + 1);

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    arb_state_e      r_state;
    logic [IdxW-1:0] r_grant_idx;
    logic [IdxW-1:0] r_last_grant;
    logic [IdxW-1:0] r_owner_q [OwnerDepth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic             w_winner_valid;
    logic [IdxW-1:0]  w_winner_idx;
    logic             w_gnt_valid;
    logic [IdxW-1:0]  w_gnt_idx;
    logic             w_empty;
    logic [IdxW-1:0]  w_owner;
    logic             w_issue;
    logic             w_pop;
    logic [NrReq-1:0] w_req_ready;
    logic [NrReq-1:0] w_rsp_valid;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(OwnerDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin : rr_search
        logic [IdxW-1:0] cand;
        w_winner_valid = 1'b0;
        w_winner_idx   = '0;
        cand           = '0;
        for (int i = 0; i < NrReq; i++) begin
            cand = IdxW'((int'(r_last_grant) + 1 + i) % NrReq);
            if (!w_winner_valid && bus.req_valid_i[cand]) begin
                w_winner_valid = 1'b1;
                w_winner_idx   = cand;
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_owner = r_owner_q[r_rd_ptr];

    // Uses the registered count only, so a same-cycle pop never frees a slot early.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = w_winner_idx;
        if (r_state == ARB_LOCK) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = r_grant_idx;
        end else if (r_count < CntW'(OwnerDepth)) begin
            w_gnt_valid = w_winner_valid;
        end
    end

    always_comb begin
        w_req_ready = '0;
        w_rsp_valid = '0;
        if (bus.div_valid_o) w_req_ready[w_gnt_idx] = bus.div_ready_i;
        if (!rst_i && !w_empty && bus.div_valid_i) w_rsp_valid[w_owner] = 1'b1;
    end

    assign bus.div_valid_o     = w_gnt_valid && !rst_i;
    assign bus.req_ready_o     = w_req_ready;
    assign bus.div_operand_a_o = bus.req_operand_a_i[w_gnt_idx];
    assign bus.div_operand_b_o = bus.req_operand_b_i[w_gnt_idx];
    assign bus.div_op_o        = bus.req_op_i[w_gnt_idx];
    assign bus.div_vew_o       = bus.req_vew_i[w_gnt_idx];
    assign bus.div_be_o        = bus.req_be_i[w_gnt_idx];
    assign bus.div_mask_o      = bus.req_mask_i[w_gnt_idx];

    assign bus.div_ready_o  = !rst_i && !w_empty && bus.rsp_ready_i[w_owner];
    assign bus.rsp_valid_o  = w_rsp_valid;
    assign bus.rsp_result_o = bus.div_result_i;
    assign bus.rsp_mask_o   = bus.div_mask_i;
    assign bus.busy_o       = !rst_i && !w_empty;

    assign w_issue = bus.div_valid_o && bus.div_ready_i;
    assign w_pop   = bus.div_valid_i && bus.div_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ARB_IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= IdxW'(NrReq - 1);
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_gnt_valid && !bus.div_ready_i) begin
                        r_state     <= ARB_LOCK;
                        r_grant_idx <= w_gnt_idx;
                    end
                end
                ARB_LOCK: begin
                    if (bus.div_ready_i) r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
            if (w_issue) begin
                r_wr_ptr     <= ptr_inc(r_wr_ptr);
                r_last_grant <= w_gnt_idx;
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Owner storage needs no reset: entries are only read while the count is non-zero.
    always_ff @(posedge clk_i) begin
        if (w_issue) r_owner_q[r_wr_ptr] <= w_gnt_idx;
    end

    a_rsp_needs_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.div_valid_i |-> !w_empty);

    a_lock_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == ARB_LOCK) |-> bus.req_valid_i[r_grant_idx]);
endmodule

// File: doc/simd_div_arbiter.md
SIMD_DIV_ARBITER -- requirements
Module: simd_div_arbiter

Interface
- REQ-001 SHALL: param NrReq, default 2, number of requesters sharing one divider; legal range 2..8.
- REQ-002 SHALL: param OwnerDepth, default 2, depth of the owner-tracking FIFO (max in-flight divisions).
- REQ-003 SHALL: clk_i  in  1  single clock; every register samples on its rising edge.
- REQ-004 SHALL: rst_i  in  1  reset; synchronous, active-high.
- REQ-005 SHALL: req_valid_i / req_ready_o  in/out  [NrReq]  per-requester issue handshake.
- REQ-006 SHALL: req_operand_a_i, req_operand_b_i  in  [NrReq][64]  operand elen_t per requester.
- REQ-007 SHALL: req_op_i  in  [NrReq] ara_op_e  operation; req_vew_i  in  [NrReq] vew_e  element width.
- REQ-008 SHALL: req_be_i, req_mask_i  in  [NrReq][8]  byte enable and mask (strb_t).
- REQ-009 SHALL: div_valid_o / div_ready_i  out/in  1  issue handshake toward the divider.
- REQ-010 SHALL: div_operand_a_o, div_operand_b_o [64], div_op_o, div_vew_o, div_be_o [8], div_mask_o [8]  out  muxed request fields.
- REQ-011 SHALL: div_valid_i / div_ready_o  in/out  1  result handshake from the divider; div_result_i [64] and div_mask_i [8]  in.
- REQ-012 SHALL: rsp_valid_o / rsp_ready_i  out/in  [NrReq]  per-requester result handshake.
- REQ-013 SHALL: rsp_result_o [64] and rsp_mask_o [8]  out  broadcast result and mask; meaningful only where rsp_valid_o is set.
- REQ-014 SHALL: busy_o  out  1  high while the owner FIFO is non-empty.

Function
- REQ-015 SHALL: arbitration is round-robin; the search starts at requester (last_grant_q+1) mod NrReq; last_grant_q resets to NrReq-1, so requester 0 has first priority.
- REQ-016 SHALL: a grant is made only when the registered FIFO count is below OwnerDepth; a pop in the same cycle does not allow a grant.
- REQ-017 SHALL: grant FSM has states ARB_IDLE and ARB_LOCK; in ARB_IDLE the winner is chosen combinationally among the asserted req_valid_i.
- REQ-018 SHALL: div_valid_o = 1 when a winner exists; div_* fields mirror the winner's req_* fields in the same cycle.
- REQ-019 SHALL: req_ready_o[k] = div_ready_i when k is granted, else 0; at most one bit is set per cycle.
- REQ-020 SHALL: if div_valid_o && !div_ready_i, the FSM enters ARB_LOCK and holds that grant index until the handshake completes.
- REQ-021 SHALL: in ARB_LOCK, no re-arbitration occurs and the grant is kept stable even if other requesters assert.
- REQ-022 SHALL: on an issue handshake, the grant index is pushed into the owner FIFO, last_grant_q is updated, and the FSM goes to ARB_IDLE.
- REQ-023 SHALL: the FIFO head (owner) selects the response; rsp_valid_o[owner] = div_valid_i && !empty, all other bits 0.
- REQ-024 SHALL: div_ready_o = rsp_ready_i[owner] && !empty; a result handshake pops the FIFO.
- REQ-025 SHALL: rsp_result_o / rsp_mask_o pass through div_result_i / div_mask_i combinationally; zero latency both ways.
- REQ-026 SHALL: a push and a pop in the same cycle leave the count unchanged; FIFO pointers wrap modulo OwnerDepth.
- REQ-027 SHALL: div_valid_i while the FIFO is empty is a protocol error; div_ready_o stays 0 and a simulation assertion fires.
- REQ-028 SHALL: a requester deasserting req_valid_i while in ARB_LOCK is a protocol violation and is flagged by assertion.

Reset
- REQ-029 SHALL: while rst_i is high, the FSM goes to ARB_IDLE, the FIFO is emptied (count 0), and last_grant_q = NrReq-1.
- REQ-030 SHALL: during reset, all handshake outputs are 0 and busy_o = 0.
- REQ-031 SHALL: a reset asserted mid-operation discards in-flight ownership; the divider must be reset in the same cycle.

Verification
- REQ-032 SHALL: single requester: req_valid_i=01, op VDIVU, a=100, b=7, div_ready_i=1 -> handshake cycle 0; result 14 returned on rsp_valid_o=01.
- REQ-033 SHALL: contention: req_valid_i=11 held after reset -> grant sequence 0,1,0,1; responses return in the same order.
- REQ-034 SHALL: backpressure: div_ready_i=0 for 5 cycles with req 1 granted, then req 0 asserts -> grant stays 1 and div_* fields stay stable until the handshake.
- REQ-035 SHALL: FIFO full: 2 issued, no results taken -> div_valid_o=0; the third issue occurs one cycle after the first pop, never the same cycle.
- REQ-036 SHALL: response stall: div_valid_i=1 with owner 1 and rsp_ready_i=01 -> div_ready_o=0 and the FIFO is not popped.
- REQ-037 SHALL: reset with 2 in flight -> next cycle busy_o=0, count 0, and requester 0 wins the first arbitration.
